sba_mem_responder: RTL and testbench
====================================

SBA_MEM_RESPONDER -- requirements
Module: sba_mem_responder

Interface
REQ-001 SHALL have parameter BusWidth, default 32, data/address width in bits; legal values are 32 and 64.
REQ-002 SHALL have parameter Depth, default 16, number of BusWidth-wide memory words; a power of two, at least 2.
REQ-003 SHALL have parameter GntDelay, default 0, number of wait cycles before grant; legal range 0..7.
REQ-004 SHALL have a single clock and a synchronous, active-high reset. Ports follow; ports ending _i are inputs and ports ending _o are outputs.
- clk_i  input  1  clock; all state changes on its rising edge.
- rst_i  input  1  synchronous active-high reset.
- req_i  input  1  request from the initiator; held high until gnt_o is seen.
- add_i  input  BusWidth  byte address.
- we_i  input  1  1 = write, 0 = read.
- wdata_i  input  BusWidth  write data.
- be_i  input  BusWidth/8  byte enables for writes.
- gnt_o  output  1  request accepted this cycle (combinational).
- r_valid_o  output  1  one-cycle response pulse, for both reads and writes.
- r_rdata_o  output  BusWidth  read data, valid while r_valid_o is high.
- err_o  output  1  error response, valid while r_valid_o is high.
- busy_o  output  1  high whenever the state is not IDLE.

Function
REQ-005 SHALL implement the states IDLE, WAIT and RESP.
REQ-006 In IDLE with req_i=1 and GntDelay=0, SHALL assert gnt_o in the same cycle, capture the transaction and go to RESP.
REQ-007 In IDLE with req_i=1 and GntDelay>0, SHALL load the counter with GntDelay-1, keep gnt_o=0 and go to WAIT.
REQ-008 In WAIT, SHALL decrement the counter each cycle. When the counter is 0 and req_i=1, it SHALL assert gnt_o, capture the transaction and go to RESP.
REQ-009 In WAIT, if req_i drops to 0 in any cycle, SHALL return to IDLE without a grant, without touching memory and without a response (abort).
REQ-010 The add/we/wdata/be values SHALL be sampled only in the gnt_o cycle; changes to them at any other time SHALL have no effect.
REQ-011 In RESP, SHALL drive r_valid_o=1 for exactly one cycle, exactly 1 cycle after gnt_o, then return to IDLE. gnt_o SHALL be 0 in RESP, so there is at most one grant every 2 cycles.
REQ-012 Word index SHALL be add_i[log2(Depth)+log2(BusWidth/8)-1 : log2(BusWidth/8)]. The low byte-offset bits SHALL be ignored for indexing.
REQ-013 An address is out of range when add_i >= Depth*BusWidth/8. For such an access, r_valid_o SHALL still pulse with err_o=1 and r_rdata_o=0, and a write SHALL be suppressed.
REQ-014 A granted in-range write SHALL update only the bytes whose be_i bit is 1, at the gnt_o clock edge. If be_i=0, memory SHALL be unchanged and the response still issued.
REQ-015 A granted in-range read SHALL return the full word, registered at the gnt_o edge, on r_rdata_o during RESP, with err_o=0.
REQ-016 A read following a write to the same word SHALL return the newly written data.
REQ-017 Outside RESP, r_rdata_o and err_o SHALL be 0.
REQ-018 busy_o SHALL be 0 in IDLE and 1 in WAIT and RESP.

Reset
REQ-019 With rst_i=1 at a clock edge, SHALL enter IDLE, clear the counter and clear all memory words to 0.
REQ-020 gnt_o, r_valid_o, r_rdata_o, err_o and busy_o SHALL be 0 during and after reset until the next request. gnt_o SHALL be forced to 0 while rst_i=1.
REQ-021 Reset asserted in WAIT or RESP SHALL abandon the transaction; no r_valid_o pulse SHALL follow reset.

Verification
REQ-022 With GntDelay=0: write add=0x8, wdata=0xDEADBEEF, be=0xF, then read add=0x8 -> each gnt_o in the req_i cycle, r_valid_o 1 cycle later, read returns 0xDEADBEEF with err_o=0.
REQ-023 With word 2 = 0xDEADBEEF: write add=0x8, wdata=0x11223344, be=0x2, then read -> returns 0xDEAD33EF.
REQ-024 With GntDelay=3: read request held -> gnt_o in the 4th cycle of req_i, r_valid_o in the 5th, busy_o=1 from cycle 2 through cycle 5.
REQ-025 With GntDelay=3: req_i dropped in cycle 2 -> no gnt_o, no r_valid_o, IDLE by cycle 3, memory unchanged.
REQ-026 With Depth=16, BusWidth=32: write then read at add=0x40 -> both respond with err_o=1 and r_rdata_o=0, and word 0 is unchanged.
REQ-027 Reset pulse asserted in RESP -> r_valid_o=0 in the following cycle; a subsequent read of any word returns 0.

Source files
------------

// File: rtl/sba_mem_responder.sv
// Single-port memory responder: grants a request after an optional
// fixed wait, performs a byte-masked write or full-word read, and
// returns a one-cycle response with an out-of-range error flag.
module sba_mem_responder #(
    parameter int unsigned BusWidth = 32,
    parameter int unsigned Depth    = 16,
    parameter int unsigned GntDelay = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_i,
    input  logic [BusWidth-1:0]   add_i,
    input  logic                  we_i,
    input  logic [BusWidth-1:0]   wdata_i,
    input  logic [BusWidth/8-1:0] be_i,
    output logic                  gnt_o,
    output logic                  r_valid_o,
    output logic [BusWidth-1:0]   r_rdata_o,
    output logic                  err_o,
    output logic                  busy_o
);

    localparam int unsigned NumBytes = BusWidth / 8;
    localparam int unsigned OffW     = $clog2(NumBytes);
    localparam int unsigned IdxW     = $clog2(Depth);
    localparam int unsigned MemBytes = Depth * NumBytes;
    localparam int unsigned CntW     = 3;
    localparam int unsigned GntLoad  = (GntDelay > 0) ? (GntDelay - 1) : 0;
    localparam bit          NoDelay  = (GntDelay == 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [BusWidth-1:0] mem_q [Depth];
    logic [BusWidth-1:0] rdata_q;
    logic                err_q;
    logic [IdxW-1:0]     idx;
    logic                oor;

    // Word index from the address, ignoring the byte-offset bits
    assign idx = add_i[IdxW+OffW-1:OffW];
    assign oor = (add_i >= BusWidth'(MemBytes));

    // State and wait-counter registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: optional grant wait, abort on dropped request, single response cycle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (req_i) begin
                    if (NoDelay) begin
                        state_d = RESP;
                    end else begin
                        cnt_d   = CntW'(GntLoad);
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!req_i) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decoded from state; everything is held low while reset is asserted
    always_comb begin
        gnt_o     = 1'b0;
        r_valid_o = 1'b0;
        r_rdata_o = '0;
        err_o     = 1'b0;
        busy_o    = 1'b0;
        if (!rst_i) begin
            unique case (state_q)
                IDLE: begin
                    gnt_o = req_i && NoDelay;
                end
                WAIT: begin
                    busy_o = 1'b1;
                    gnt_o  = req_i && (cnt_q == '0);
                end
                RESP: begin
                    busy_o    = 1'b1;
                    r_valid_o = 1'b1;
                    r_rdata_o = rdata_q;
                    err_o     = err_q;
                end
                default: begin
                    busy_o = 1'b0;
                end
            endcase
        end
    end

    // Memory array and response capture, both updated at the grant edge
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (gnt_o) begin
            err_q   <= oor;
            rdata_q <= (!oor && !we_i) ? mem_q[idx] : '0;
            if (!oor && we_i) begin
                for (int b = 0; b < NumBytes; b++) begin
                    if (be_i[b]) begin
                        mem_q[idx][8*b +: 8] <= wdata_i[8*b +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sba_mem_responder.sv
// Bench for sba_mem_responder: two instances (no grant wait and a
// three-cycle wait) checked every cycle against a transaction-level model.
module tb_sba_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req   [2];
    logic [31:0] add   [2];
    logic        we    [2];
    logic [31:0] wdata [2];
    logic [3:0]  be    [2];
    logic        gnt   [2];
    logic        rv    [2];
    logic [31:0] rdata [2];
    logic        err   [2];
    logic        busy  [2];

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sba_mem_responder #(.BusWidth(32), .Depth(16), .GntDelay(0)) u_d0 (
        .clk_i(clk), .rst_i(rst), .req_i(req[0]), .add_i(add[0]), .we_i(we[0]),
        .wdata_i(wdata[0]), .be_i(be[0]), .gnt_o(gnt[0]), .r_valid_o(rv[0]),
        .r_rdata_o(rdata[0]), .err_o(err[0]), .busy_o(busy[0])
    );

    sba_mem_responder #(.BusWidth(32), .Depth(16), .GntDelay(3)) u_d3 (
        .clk_i(clk), .rst_i(rst), .req_i(req[1]), .add_i(add[1]), .we_i(we[1]),
        .wdata_i(wdata[1]), .be_i(be[1]), .gnt_o(gnt[1]), .r_valid_o(rv[1]),
        .r_rdata_o(rdata[1]), .err_o(err[1]), .busy_o(busy[1])
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: a grant comes after `delay` prior cycles of held request
    int          delay   [2] = '{0, 3};
    int          m_held  [2] = '{0, 0};
    bit          m_resp  [2] = '{0, 0};
    bit          m_wr    [2];
    bit          m_err   [2];
    logic [31:0] m_rdata [2];
    logic [31:0] mmem    [2][16];

    // Compare every output of both instances each cycle, then advance the model
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            bit          eg, ev, eb, ee, oor;
            logic [31:0] er;
            int          wi;
            eb = !rst && (m_resp[k] || m_held[k] > 0);
            ev = !rst && m_resp[k];
            ee = ev && m_err[k];
            er = ev ? m_rdata[k] : 32'h0;
            eg = !rst && !m_resp[k] && req[k] && (m_held[k] == delay[k]);
            check($sformatf("gnt[%0d]", k), 64'(gnt[k]), 64'(eg));
            check($sformatf("r_valid[%0d]", k), 64'(rv[k]), 64'(ev));
            check($sformatf("busy[%0d]", k), 64'(busy[k]), 64'(eb));
            check($sformatf("err[%0d]", k), 64'(err[k]), 64'(ee));
            if (!ev || !m_wr[k] || m_err[k])
                check($sformatf("rdata[%0d]", k), 64'(rdata[k]), 64'(er));

            if (rst) begin
                m_resp[k] = 0;
                m_held[k] = 0;
                for (int i = 0; i < 16; i++) mmem[k][i] = 32'h0;
            end else if (eg) begin
                oor        = (add[k] >= 32'd64);
                wi         = int'(add[k][5:2]);
                m_err[k]   = oor;
                m_wr[k]    = we[k];
                m_rdata[k] = (!oor && !we[k]) ? mmem[k][wi] : 32'h0;
                if (!oor && we[k])
                    for (int b = 0; b < 4; b++)
                        if (be[k][b]) mmem[k][wi][8*b +: 8] = wdata[k][8*b +: 8];
                m_resp[k] = 1;
                m_held[k] = 0;
            end else if (m_resp[k]) begin
                m_resp[k] = 0;
            end else if (req[k]) begin
                m_held[k]++;
            end else begin
                m_held[k] = 0;
            end
        end
    end

    // One full transaction: hold request until granted, then collect the response
    task automatic txn(input int k, input bit w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] b, input bit scramble,
                       output logic [31:0] rd, output bit e, output int gc, output int vc);
        int cyc = 0;
        bit got = 0;
        rd = 32'h0; e = 0; gc = 0; vc = 0;
        @(posedge clk); #1;
        req[k] = 1; we[k] = w; add[k] = a; wdata[k] = d; be[k] = b;
        while (!got && cyc < 20) begin
            @(negedge clk); cyc++;
            if (gnt[k]) begin
                got = 1; gc = cyc;
            end else begin
                @(posedge clk); #1;
                if (scramble) begin
                    we[k] = 1'($urandom); add[k] = $urandom_range(0, 'h4F);
                    wdata[k] = $urandom; be[k] = 4'($urandom);
                end
            end
        end
        @(posedge clk); #1;
        req[k] = 0; we[k] = 1'($urandom); add[k] = $urandom; wdata[k] = $urandom; be[k] = 4'($urandom);
        if (!got) begin
            check($sformatf("gnt_timeout[%0d]", k), 64'(0), 64'(1));
        end else begin
            @(negedge clk); cyc++;
            if (rv[k]) begin vc = cyc; rd = rdata[k]; e = err[k]; end
        end
    endtask

    // Request held for `hold` cycles then dropped before the grant could come
    task automatic abort_req(input int k, input int hold);
        @(posedge clk); #1;
        req[k] = 1; we[k] = 1'($urandom); add[k] = $urandom_range(0, 'h4F);
        wdata[k] = $urandom; be[k] = 4'($urandom);
        repeat (hold) @(posedge clk);
        #1 req[k] = 0;
    endtask

    initial begin
        logic [31:0] rd;
        bit          e;
        int          gc, vc;

        rst = 1;
        for (int k = 0; k < 2; k++) begin
            req[k] = 0; we[k] = 0; add[k] = 0; wdata[k] = 0; be[k] = 0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 0;

        // Out-of-range write and read on instance 0; word 0 stays cleared
        txn(0, 1, 32'h40, 32'hCAFEF00D, 4'hF, 0, rd, e, gc, vc);
        check("oor_wr_err", 64'(e), 64'(1));
        check("oor_wr_rdata", 64'(rd), 64'(0));
        txn(0, 0, 32'h40, 32'h0, 4'h0, 0, rd, e, gc, vc);
        check("oor_rd_err", 64'(e), 64'(1));
        check("oor_rd_rdata", 64'(rd), 64'(0));
        txn(0, 0, 32'h0, 32'h0, 4'h0, 0, rd, e, gc, vc);
        check("word0_unchanged", 64'(rd), 64'(0));

        // Zero-wait write then read-back
        txn(0, 1, 32'h8, 32'hDEADBEEF, 4'hF, 0, rd, e, gc, vc);
        check("d0_wr_gnt_cycle", 64'(gc), 64'(1));
        check("d0_wr_valid_cycle", 64'(vc), 64'(2));
        txn(0, 0, 32'h8, 32'h0, 4'h0, 0, rd, e, gc, vc);
        check("d0_rd_gnt_cycle", 64'(gc), 64'(1));
        check("d0_rd_valid_cycle", 64'(vc), 64'(2));
        check("d0_rd_data", 64'(rd), 64'(32'hDEADBEEF));
        check("d0_rd_err", 64'(e), 64'(0));

        // Single-byte masked write
        txn(0, 1, 32'h8, 32'h11223344, 4'h2, 0, rd, e, gc, vc);
        txn(0, 0, 32'hA, 32'h0, 4'h0, 0, rd, e, gc, vc);
        check("be_merge_data", 64'(rd), 64'(32'hDEAD33EF));

        // Reset asserted during the response cycle kills the pulse and clears memory
        @(posedge clk); #1;
        req[0] = 1; we[0] = 0; add[0] = 32'h8;
        @(negedge clk);
        check("rstresp_gnt", 64'(gnt[0]), 64'(1));
        @(posedge clk); #1;
        req[0] = 0; rst = 1;
        @(negedge clk);
        check("rstresp_valid_in_rst", 64'(rv[0]), 64'(0));
        check("rstresp_gnt_in_rst", 64'(gnt[0]), 64'(0));
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        check("rstresp_valid_after", 64'(rv[0]), 64'(0));
        txn(0, 0, 32'h8, 32'h0, 4'h0, 0, rd, e, gc, vc);
        check("rstresp_word_cleared", 64'(rd), 64'(0));

        // Three-cycle grant wait on instance 1
        txn(1, 0, 32'h8, 32'h0, 4'h0, 0, rd, e, gc, vc);
        check("d3_gnt_cycle", 64'(gc), 64'(4));
        check("d3_valid_cycle", 64'(vc), 64'(5));

        // Abort: request only in cycle 1, dropped in cycle 2
        @(posedge clk); #1;
        req[1] = 1; we[1] = 1; add[1] = 32'h4; wdata[1] = 32'hFFFFFFFF; be[1] = 4'hF;
        @(negedge clk);
        check("abort_c1_gnt", 64'(gnt[1]), 64'(0));
        @(posedge clk); #1 req[1] = 0;
        @(negedge clk);
        check("abort_c2_busy", 64'(busy[1]), 64'(1));
        @(negedge clk);
        check("abort_c3_busy", 64'(busy[1]), 64'(0));
        check("abort_c3_valid", 64'(rv[1]), 64'(0));
        txn(1, 0, 32'h4, 32'h0, 4'h0, 0, rd, e, gc, vc);
        check("abort_mem_unchanged", 64'(rd), 64'(0));

        // Randomized traffic on both instances
        for (int n = 0; n < 300; n++) begin
            int k;
            k = n % 2;
            repeat ($urandom_range(0, 2)) @(posedge clk);
            if (k == 1 && $urandom_range(0, 5) == 0) begin
                abort_req(1, $urandom_range(1, 3));
            end else begin
                txn(k, 1'($urandom), $urandom_range(0, 'h4F), $urandom, 4'($urandom),
                    1'($urandom), rd, e, gc, vc);
            end
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
